// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared timing constants, state type and phase helper for the USB receive timer
//
// Holds the bit-period geometry (8 clocks per USB bit at 96 MHz), the sample
// phase within a bit, the bit-stuffing run length and the receive FSM state
// type. All of these are used by usb_rx_timer.
package usb_rx_pkg;

  localparam int BIT_PERIOD = 8;
  localparam int SAMPLE_PT  = 3;
  localparam int MAX_ONES   = 6;

  localparam int PHASE_W = $clog2(BIT_PERIOD);
  localparam int ONES_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    STUFF  = 2'd2
  } rx_state_t;

  // Free-running phase advance: 0,1,..,BIT_PERIOD-1,0,...
  function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] phase);
    if (phase == PHASE_W'(BIT_PERIOD - 1)) begin
      return '0;
    end
    return phase + 1'b1;
  endfunction

endpackage

// File: rtl/usb_rx_timer_if.sv
// rtl/usb_rx_timer_if.sv - bit-timing bundle between the USB receive front end and the timer
//
// Signals:
//   d_edge        front end -> timer  one-cycle pulse on any d_plus transition
//   rcving        front end -> timer  high while a packet is being received
//   d_orig        front end -> timer  NRZI-decoded bit
//   shift_enable  timer -> front end  strobe to decode and the rx shift register
//   byte_received timer -> front end  pulse after 8 data bits have been shifted
//   stuff_err     timer -> front end  pulse when a stuffed-bit position carried a 1
// master: the receive front end; slave: usb_rx_timer.
interface usb_rx_timer_if;

  logic d_edge;
  logic rcving;
  logic d_orig;
  logic shift_enable;
  logic byte_received;
  logic stuff_err;

  modport master (
    output d_edge,
    output rcving,
    output d_orig,
    input  shift_enable,
    input  byte_received,
    input  stuff_err
  );

  modport slave (
    input  d_edge,
    input  rcving,
    input  d_orig,
    output shift_enable,
    output byte_received,
    output stuff_err
  );

endinterface

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - parameterised up-counter with synchronous clear and rollover strobe
//
// Ports:
//   clk           system clock
//   n_rst         asynchronous active-low reset, clears the count
//   clear         synchronous clear, wins over counting
//   count_enable  advance the count by one this cycle
//   rollover_val  number of counts per wrap; the count runs 0..rollover_val-1
//   rollover_flag high in the cycle whose count_enable wraps the count to 0
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q;

  // Combinational so the owner can register its own one-cycle pulse from it.
  assign rollover_flag = count_enable && !clear && (count_q == rollover_val - 1'b1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (clear || rollover_flag) begin
      count_q <= '0;
    end else if (count_enable) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/usb_rx_timer.sv
// rtl/usb_rx_timer.sv - USB full-speed receive bit timer with bit-stuff removal and byte framing
//
// Ports:
//   clk    96 MHz system clock, 8 clocks per USB bit
//   n_rst  asynchronous active-low reset
//   bus    usb_rx_timer_if.slave:
//            d_edge, rcving, d_orig in; shift_enable, byte_received, stuff_err out
//
// A 3-bit phase counter tracks position inside the current bit and is pulled
// to 1 on every line edge, so the sample point (phase 3) sits near mid-bit.
// After six consecutive 1s the next sample point is the stuffed bit: it is
// consumed without a shift_enable and flagged on stuff_err if it is a 1.
module usb_rx_timer
  import usb_rx_pkg::*;
(
  input  logic           clk,
  input  logic           n_rst,
  usb_rx_timer_if.slave  bus
);

  localparam logic [PHASE_W-1:0] SAMPLE_PHASE = PHASE_W'(SAMPLE_PT);
  localparam logic [PHASE_W-1:0] EDGE_PHASE   = PHASE_W'(1);
  localparam logic [ONES_W-1:0]  ONES_LIMIT   = ONES_W'(MAX_ONES);
  localparam logic [ONES_W-1:0]  ONES_LAST    = ONES_W'(MAX_ONES - 1);
  localparam logic [3:0]         BITS_PER_BYTE = 4'd8;

  rx_state_t          state_q;
  logic [PHASE_W-1:0] phase_q;
  logic [ONES_W-1:0]  ones_q;
  logic               stuff_err_q;
  logic               byte_received_q;
  logic               sample_pt;
  logic               byte_done;

  assign sample_pt = bus.rcving && (phase_q == SAMPLE_PHASE);

  // Combinational so the decode stage sees the strobe in the sample cycle itself.
  assign bus.shift_enable  = sample_pt && (state_q == SAMPLE);
  assign bus.byte_received = byte_received_q;
  assign bus.stuff_err     = stuff_err_q;

  // Phase counter. An edge on the sample cycle still lets that cycle sample
  // (sample_pt uses the current phase); only the next phase is resynchronised.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q <= '0;
    end else if (!bus.rcving) begin
      phase_q <= '0;
    end else if (bus.d_edge) begin
      phase_q <= EDGE_PHASE;
    end else begin
      phase_q <= next_phase(phase_q);
    end
  end

  // Receive FSM with ones-run tracking and registered output pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      ones_q          <= '0;
      stuff_err_q     <= 1'b0;
      byte_received_q <= 1'b0;
    end else begin
      stuff_err_q     <= 1'b0;
      byte_received_q <= byte_done;
      if (!bus.rcving) begin
        state_q <= IDLE;
        ones_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= SAMPLE;
            ones_q  <= '0;
          end
          SAMPLE: begin
            if (sample_pt) begin
              if (!bus.d_orig) begin
                ones_q <= '0;
              end else if (ones_q == ONES_LAST) begin
                ones_q  <= ONES_LIMIT;
                state_q <= STUFF;
              end else begin
                ones_q <= ones_q + 1'b1;
              end
            end
          end
          STUFF: begin
            // The stuffed bit is dropped either way; a 1 here is a line error.
            if (sample_pt) begin
              ones_q      <= '0;
              state_q     <= SAMPLE;
              stuff_err_q <= bus.d_orig;
            end
          end
          default: begin
            state_q <= IDLE;
            ones_q  <= '0;
          end
        endcase
      end
    end
  end

  // Bit counter only sees real data shifts, so stuffed bits never count.
  flex_counter #(
    .NUM_CNT_BITS (4)
  ) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (!bus.rcving),
    .count_enable  (bus.shift_enable),
    .rollover_val  (BITS_PER_BYTE),
    .rollover_flag (byte_done)
  );

endmodule
